// File: rtl/sockit_spi_arb.sv
// sockit_spi_arb: N-channel command/response arbiter for the sockit_spi CPU-side datapath.
// One requester owns the command stream from grant until its last beat. Requesters that
// expect a response are logged in an order FIFO so response beats are routed back to them
// in issue order, independent of where command arbitration has moved since.
module sockit_spi_arb #(
  parameter int CN  = 3,
  parameter int DW  = 32,
  parameter int FD  = 4,
  parameter int PRI = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CN-1:0]           req_vld,
  input  logic [CN*DW-1:0]        req_dat,
  input  logic [CN-1:0]           req_lst,
  input  logic [CN-1:0]           req_rsp,
  output logic [CN-1:0]           req_rdy,
  output logic                    out_vld,
  output logic [DW-1:0]           out_dat,
  output logic                    out_lst,
  input  logic                    out_rdy,
  input  logic                    rsp_vld,
  input  logic [DW-1:0]           rsp_dat,
  input  logic                    rsp_lst,
  output logic                    rsp_rdy,
  output logic [CN-1:0]           chn_vld,
  output logic [DW-1:0]           chn_dat,
  output logic                    chn_lst,
  input  logic [CN-1:0]           chn_rdy,
  output logic [CN-1:0]           own,
  output logic [$clog2(FD+1)-1:0] ord_cnt
);

  localparam int IW = (CN > 1) ? $clog2(CN) : 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] win, win_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [CN-1:0] own_nxt;
  logic          first, first_nxt;

  logic [CN-1:0] elig;
  logic [IW-1:0] scan;
  logic [IW-1:0] pick;
  logic          found;

  logic          lock;
  logic          out_xfer;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;

  logic [IW-1:0] mem [FD];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [IW-1:0] head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full and empty come from the registered count, so a pop this cycle cannot open a grant.
  assign empty = (ord_cnt == '0);
  assign full  = (ord_cnt == CW'(FD));

  // While the FIFO is full only requesters without a response may compete.
  assign elig = full ? (req_vld & ~req_rsp) : req_vld;

  // Winner search: round-robin starts after the previous winner; fixed priority starts at 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    scan  = (PRI != 0) ? IW'(CN - 1) : last;
    for (int i = 0; i < CN; i++) begin
      scan = (scan == IW'(CN - 1)) ? '0 : scan + 1'b1;
      if (!found && elig[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  // Command path is a pure mux of the locked requester; out_vld never looks at out_rdy.
  assign lock     = (state == LOCK);
  assign out_vld  = lock & req_vld[win];
  assign out_dat  = req_dat[int'(win) * DW +: DW];
  assign out_lst  = lock & req_lst[win];
  assign req_rdy  = (lock && out_rdy) ? own : '0;
  assign out_xfer = out_vld & out_rdy;
  assign push     = out_xfer & first & req_rsp[win];

  // Response path routes to the requester at the FIFO head; nothing is accepted when empty.
  assign head    = mem[rptr];
  assign rsp_rdy = ~empty & chn_rdy[head];
  assign chn_vld = (rsp_vld && !empty) ? (CN'(1) << head) : '0;
  assign chn_dat = rsp_dat;
  assign chn_lst = rsp_lst;
  assign pop     = rsp_vld & rsp_rdy & rsp_lst;

  // Next-state logic: grant from IDLE, hold the lock until the last beat transfers.
  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    last_nxt  = last;
    own_nxt   = own;
    first_nxt = first;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = LOCK;
          win_nxt   = pick;
          own_nxt   = CN'(1) << pick;
          first_nxt = 1'b1;
          if (PRI == 0) last_nxt = pick;
        end
      end
      LOCK: begin
        if (out_xfer) first_nxt = 1'b0;
        if (out_xfer && req_lst[win]) begin
          state_nxt = IDLE;
          own_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter state register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      win   <= '0;
      last  <= IW'(CN - 1);
      own   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      last  <= last_nxt;
      own   <= own_nxt;
      first <= first_nxt;
    end
  end

  // Order FIFO storage holds the owner index of each outstanding response transaction.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= win;
  end

  // Order FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ord_cnt <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   ord_cnt <= ord_cnt + 1'b1;
        2'b01:   ord_cnt <= ord_cnt - 1'b1;
        default: ord_cnt <= ord_cnt;
      endcase
    end
  end

endmodule

// File: doc/sockit_spi_arb.md
# sockit_spi_arb

Parametrised N-channel command/response arbiter for the sockit_spi CPU-side datapath. It replaces the fixed three-way XIP/DMA/REG multiplexer with a generic block. The block selects one requester per transaction and holds the lock until that transaction's last beat. It records which requester owns each outstanding response in an order FIFO, so returning SPI data is routed back to the correct requester even after the command side has moved on.

## Interface
- `CN`, 3: requester channel count (≥2); channel 0 = XIP by convention.
- `DW`, 32: command/response data width.
- `FD`, 4: order FIFO depth (outstanding response transactions, ≥1).
- `PRI`, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- `clk`  in  1  block clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_vld`  in  CN  per-channel command beat valid.
- `req_dat`  in  CN*DW  per-channel command data; channel i at [i*DW +: DW].
- `req_lst`  in  CN  last beat of transaction.
- `req_rsp`  in  CN  transaction expects response; sampled on first beat only.
- `req_rdy`  out  CN  per-channel command ready.
- `out_vld`, `out_dat` (DW), `out_lst`  out  muxed command stream to RPO/CDC.
- `out_rdy`  in  1  downstream ready.
- `rsp_vld`, `rsp_dat` (DW), `rsp_lst`  in  response stream from RPI/CDC.
- `rsp_rdy`  out  1  response ready.
- `chn_vld`  out  CN  per-channel response valid.
- `chn_dat`  out  DW  response data, broadcast to all channels.
- `chn_lst`  out  1  response last, broadcast.
- `chn_rdy`  in  CN  per-channel response ready.
- `own`  out  CN  one-hot current command owner; 0 when idle.
- `ord_cnt`  out  $clog2(FD+1)  order FIFO occupancy.

## Operation
- Index width IW = max(1, $clog2(CN)). Transfer on any stream means vld & rdy in the same cycle.
- Command FSM states:
  - IDLE: `own`=0, all `req_rdy`=0.
    - If any `req_vld` is set and the order FIFO is not full, pick winner w and register `own`=1<<w. Move to LOCK.
    - If the FIFO is full, arbitrate only among channels whose `req_rsp`=0. Higher-priority response requesters do not block them.
  - LOCK:
    - `out_vld`=`req_vld`[w], `out_dat`=`req_dat`[w], `out_lst`=`req_lst`[w].
    - `req_rdy`[w]=`out_rdy`; all other `req_rdy`=0.
    - First transferred beat: if `req_rsp`[w]=1, push w into the order FIFO.
    - Transfer with `out_lst`=1: go to IDLE, clear `own`.
- Round-robin: register `last` holds the index of the previous winner (reset CN-1). Search starts at `last`+1 modulo CN and wraps. `last` updates on grant only.
- Fixed priority: lowest set index wins; `last` is unused.
- Single-beat transactions (first beat = last beat) are legal; the push and the exit happen in the same cycle.
- Response path:
  - h = FIFO head index.
  - `chn_vld`[h] = `rsp_vld` & ~empty; all others 0.
  - `rsp_rdy` = `chn_rdy`[h] & ~empty.
  - Pop on a transferred response beat with `rsp_lst`=1.
  - `rsp_vld` while the FIFO is empty: stall (`rsp_rdy`=0); the beat is never dropped.
- Same-cycle FIFO push and pop: both take effect and `ord_cnt` is unchanged.
- "Full" is the registered condition `ord_cnt`==FD. A pop in the current cycle does not enable a grant in that cycle.
- Reset (`rst`=0 at an edge), including mid-transaction or with responses outstanding:
  - FSM goes to IDLE; `own`=0, `last`=CN-1, FIFO emptied, `ord_cnt`=0.
  - All `req_rdy`, `out_vld`, `chn_vld`, `rsp_rdy` = 0 in the cycle after reset.
  - In-flight beats are discarded; no partial transaction is resumed.

## Timing
- Arbitration: a request seen in IDLE at edge n gives `own` valid after edge n+1. The first beat can transfer in cycle n+1. There is one bubble cycle between back-to-back transactions.
- Command path `req`→`out` is combinational in LOCK: zero latency, full throughput (one beat per cycle while `out_rdy`=1).
- Response path is combinational through the registered head index: zero latency, one beat per cycle.
- `out_vld` must not depend on `out_rdy`. `rsp_rdy` may depend on `chn_rdy`.
- `ord_cnt` updates one edge after a push or pop.

## Test plan
- Round-robin fairness (CN=3, PRI=0): all three channels hold continuous single-beat requests. Required: `own` sequence 001, 010, 100, 001; each grant is 2 cycles apart.
- Lock hold: ch1 sends a 4-beat transaction with `out_rdy` toggling 1,0,1,0; ch0 and ch2 request throughout. Required: all 4 ch1 beats (A0..A3) appear on `out_dat` in order before any other grant; ch0/ch2 `req_rdy` stay 0.
- Response ordering: issue ch2 (rsp, 1 beat), ch0 (rsp, 1 beat), ch1 (no rsp). Then send response beats R0 (lst) and R1 (lst). Required: R0 appears on ch2 only, R1 on ch0 only; `ord_cnt` goes 1, 2, 1, 0.
- FIFO full (FD=2): two outstanding rsp transactions; ch0 requests with rsp=1 and ch1 with rsp=0. Required: ch1 granted and ch0 waits. After one response beat with `rsp_lst`=1, ch0 is granted on the following arbitration.
- Response backpressure and empty FIFO: `rsp_vld`=1 with the FIFO empty gives `rsp_rdy`=0 for 10 cycles. With head=ch1 and `chn_rdy`[1]=0, `rsp_rdy`=0 until `chn_rdy`[1] rises.
- Reset mid-operation: pull `rst` low during beat 2 of a 4-beat ch0 transaction with 1 response outstanding. Required: next cycle `own`=0, `ord_cnt`=0, `out_vld`=0; the first post-reset round-robin grant goes to ch0 (`last`=2).
